// File: rtl/arrow_ctrl.sv
// arrow_ctrl: button-driven arrow position with per-frame auto-repeat,
// per-pixel arrow window (isarrow) and once-per-frame overlay realign pulse.
//
// Ports:
//   vgaclk, reset            clock, synchronous active-high reset
//   pixelEN, hcount, vcount  pixel strobe and raster position
//   romEN                    active-video flag (window never leaves it)
//   btn_up/down/left/right   raw asynchronous buttons, active-high
//   isarrow                  current pixel is inside the arrow window
//   movearrow                one-cycle pulse after each frame tick
//   arrow_x, arrow_y         registered top-left corner of the arrow
`timescale 1ns/1ps

module arrow_ctrl #(
    parameter int ARROW_W     = 30,
    parameter int ARROW_H     = 30,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int STEP        = 2,
    parameter int HOLD_FRAMES = 15,
    parameter int X_INIT      = 305,
    parameter int Y_INIT      = 225
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic       pixelEN,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       romEN,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       isarrow,
    output logic       movearrow,
    output logic [9:0] arrow_x,
    output logic [9:0] arrow_y
);

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [10:0] XMAX11 = 11'(H_VISIBLE - ARROW_W);
    localparam logic [10:0] YMAX11 = 11'(V_VISIBLE - ARROW_H);
    localparam logic [10:0] AW11   = 11'(ARROW_W);
    localparam logic [10:0] AH11   = 11'(ARROW_H);
    localparam logic [4:0]  HOLD_LAST = 5'(HOLD_FRAMES - 1);

    // The FIRST move is taken on the very tick that enters it, so the
    // registered state only needs IDLE, HOLD and REPEAT.
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  dir_lat_q, dir_lat_d;
    logic [3:0]  btn_s1_q, btn_s1_d;
    logic [3:0]  btn_s2_q, btn_s2_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        movearrow_q, movearrow_d;

    logic [3:0]  dir;
    logic        frame_tick;
    logic        first;
    logic        move;
    logic [10:0] x_wide, y_wide;
    logic [10:0] x_inc, y_inc;
    logic [9:0]  x_dec, y_dec;
    logic [10:0] x_end, y_end;
    logic        unused_ok;

    assign unused_ok = romEN;

    // dir = {up, down, left, right}
    assign dir        = btn_s2_q;
    assign frame_tick = pixelEN && (hcount == 10'd0)
                        && (vcount == 10'(V_VISIBLE));

    assign x_wide = {1'b0, x_q};
    assign y_wide = {1'b0, y_q};
    assign x_inc  = x_wide + STEP11;
    assign y_inc  = y_wide + STEP11;
    assign x_dec  = x_q - STEP10;
    assign y_dec  = y_q - STEP10;
    assign x_end  = x_wide + AW11;
    assign y_end  = y_wide + AH11;

    always_comb begin
        btn_s1_d    = {btn_up, btn_down, btn_left, btn_right};
        btn_s2_d    = btn_s1_q;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dir_lat_d   = dir_lat_q;
        movearrow_d = frame_tick;
        first       = 1'b0;
        move        = 1'b0;
        x_d         = x_q;
        y_d         = y_q;

        if (frame_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (dir != 4'd0) first = 1'b1;
                end
                S_HOLD: begin
                    if (dir == 4'd0) begin
                        state_d = S_IDLE;
                    end else if (dir != dir_lat_q) begin
                        first = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 5'd1;
                        if (hold_cnt_d == HOLD_LAST) state_d = S_REPEAT;
                    end
                end
                S_REPEAT: begin
                    if (dir == 4'd0) begin
                        state_d = S_IDLE;
                    end else if (dir != dir_lat_q) begin
                        first = 1'b1;
                    end else begin
                        move = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (first) begin
                move       = 1'b1;
                dir_lat_d  = dir;
                hold_cnt_d = 5'd0;
                state_d    = S_HOLD;
            end
        end

        // Opposing buttons on one axis cancel; the axes are independent.
        if (move) begin
            if (dir[3] && !dir[2]) begin
                y_d = (y_wide < STEP11) ? 10'd0 : y_dec;
            end else if (dir[2] && !dir[3]) begin
                y_d = (y_inc > YMAX11) ? YMAX11[9:0] : y_inc[9:0];
            end
            if (dir[1] && !dir[0]) begin
                x_d = (x_wide < STEP11) ? 10'd0 : x_dec;
            end else if (dir[0] && !dir[1]) begin
                x_d = (x_inc > XMAX11) ? XMAX11[9:0] : x_inc[9:0];
            end
        end
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= 5'd0;
            dir_lat_q   <= 4'd0;
            btn_s1_q    <= 4'd0;
            btn_s2_q    <= 4'd0;
            x_q         <= 10'(X_INIT);
            y_q         <= 10'(Y_INIT);
            movearrow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dir_lat_q   <= dir_lat_d;
            btn_s1_q    <= btn_s1_d;
            btn_s2_q    <= btn_s2_d;
            x_q         <= x_d;
            y_q         <= y_d;
            movearrow_q <= movearrow_d;
        end
    end

    assign isarrow = ({1'b0, hcount} >= x_wide) && ({1'b0, hcount} < x_end)
                  && ({1'b0, vcount} >= y_wide) && ({1'b0, vcount} < y_end);

    assign movearrow = movearrow_q;
    assign arrow_x   = x_q;
    assign arrow_y   = y_q;

endmodule

// File: tb/tb_arrow_ctrl.sv
// tb_arrow_ctrl: directed checks of arrow_ctrl position, repeat timing,
// clamping, window generation and movearrow pulse.
`timescale 1ns/1ps

module tb_arrow_ctrl;

    logic       vgaclk = 1'b0;
    logic       reset;
    logic       pixelEN;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       romEN;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       isarrow;
    logic       movearrow;
    logic [9:0] arrow_x;
    logic [9:0] arrow_y;

    int n_cmp = 0;
    int n_bad = 0;

    arrow_ctrl dut (
        .vgaclk    (vgaclk),
        .reset     (reset),
        .pixelEN   (pixelEN),
        .hcount    (hcount),
        .vcount    (vcount),
        .romEN     (romEN),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .isarrow   (isarrow),
        .movearrow (movearrow),
        .arrow_x   (arrow_x),
        .arrow_y   (arrow_y)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vgaclk);
            #1;
        end
    endtask

    task automatic btns(input logic u, input logic d,
                        input logic l, input logic r);
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
        cycles(2);
    endtask

    // One frame tick, then confirm a single-cycle movearrow pulse.
    task automatic tick();
        @(posedge vgaclk);
        #1;
        pixelEN = 1'b1;
        hcount  = 10'd0;
        vcount  = 10'd480;
        @(posedge vgaclk);
        #1;
        pixelEN = 1'b0;
        hcount  = 10'd1;
        vcount  = 10'd0;
        chk("movearrow_hi", 32'(movearrow), 32'd1);
        @(posedge vgaclk);
        #1;
        chk("movearrow_lo", 32'(movearrow), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge vgaclk);
        #1;
        reset = 1'b1;
        cycles(2);
        chk("rst_movearrow", 32'(movearrow), 32'd0);
        reset = 1'b0;
        cycles(1);
        chk("rst_x", 32'(arrow_x), 32'd305);
        chk("rst_y", 32'(arrow_y), 32'd225);
    endtask

    task automatic win_pt(input string tag, input int h, input int v,
                          input int exp);
        hcount = 10'(h);
        vcount = 10'(v);
        #1;
        chk(tag, 32'(isarrow), 32'(exp));
    endtask

    initial begin
        int e;
        int cnt;
        reset   = 1'b1;
        pixelEN = 1'b0;
        hcount  = 10'd1;
        vcount  = 10'd0;
        romEN   = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        cycles(3);
        chk("rst_movearrow", 32'(movearrow), 32'd0);
        reset = 1'b0;
        cycles(1);
        chk("rst_x", 32'(arrow_x), 32'd305);
        chk("rst_y", 32'(arrow_y), 32'd225);

        // Window around the reset position: exactly 30x30 pixels.
        cnt = 0;
        for (int v = 215; v < 265; v++) begin
            for (int h = 295; h < 345; h++) begin
                hcount = 10'(h);
                vcount = 10'(v);
                #1;
                if (isarrow === 1'b1) cnt++;
            end
        end
        chk("win_count", 32'(cnt), 32'd900);
        win_pt("win_tl", 305, 225, 1);
        win_pt("win_br", 334, 254, 1);
        win_pt("win_right_out", 335, 225, 0);
        win_pt("win_bot_out", 305, 255, 0);
        win_pt("win_left_out", 304, 225, 0);
        win_pt("win_top_out", 305, 224, 0);
        hcount = 10'd1;
        vcount = 10'd0;
        tick();
        chk("idle_x", 32'(arrow_x), 32'd305);

        // Tap right for one frame.
        btns(0, 0, 0, 1);
        tick();
        chk("tap_x", 32'(arrow_x), 32'd307);
        btns(0, 0, 0, 0);
        tick();
        tick();
        chk("tap_after_x", 32'(arrow_x), 32'd307);

        // Hold right 20 frames: move, 14 flat ticks, then repeat.
        btns(0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = (k <= 15) ? 309 : 309 + 2 * (k - 15);
            chk("hold_right_x", 32'(arrow_x), 32'(e));
        end

        // Switch to up while repeating: immediate move, then hold again.
        btns(1, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = (k <= 15) ? 223 : 223 - 2 * (k - 15);
            if (k == 1 || k == 15 || k == 16 || k == 17)
                chk("chg_up_y", 32'(arrow_y), 32'(e));
        end
        chk("chg_up_x", 32'(arrow_x), 32'd319);

        // Reset mid-frame, then reset coinciding with a tick.
        @(posedge vgaclk);
        #1;
        btn_up  = 1'b0;
        reset   = 1'b1;
        pixelEN = 1'b1;
        hcount  = 10'd50;
        vcount  = 10'd100;
        @(posedge vgaclk);
        #1;
        chk("midrst_x", 32'(arrow_x), 32'd305);
        chk("midrst_y", 32'(arrow_y), 32'd225);
        chk("midrst_mv", 32'(movearrow), 32'd0);
        hcount = 10'd0;
        vcount = 10'd480;
        @(posedge vgaclk);
        #1;
        chk("tickrst_mv", 32'(movearrow), 32'd0);
        reset   = 1'b0;
        pixelEN = 1'b0;
        hcount  = 10'd305;
        vcount  = 10'd225;
        @(posedge vgaclk);
        #1;
        chk("postrst_mv", 32'(movearrow), 32'd0);
        chk("postrst_isarrow", 32'(isarrow), 32'd1);

        // Left clamp: 303 .. 1 then 0.
        btns(0, 0, 1, 0);
        for (int k = 1; k <= 170; k++) begin
            tick();
            e = (k <= 15) ? 303 : 303 - 2 * (k - 15);
            if (e < 0) e = 0;
            if (k == 1 || k == 15 || k == 16 || k >= 165)
                chk("left_clamp_x", 32'(arrow_x), 32'(e));
        end
        btns(0, 0, 0, 0);

        // Right clamp: 307 .. 609 then 610.
        do_reset();
        btns(0, 0, 0, 1);
        for (int k = 1; k <= 170; k++) begin
            tick();
            e = (k <= 15) ? 307 : 307 + 2 * (k - 15);
            if (e > 610) e = 610;
            if (k == 1 || k == 16 || k >= 165)
                chk("right_clamp_x", 32'(arrow_x), 32'(e));
        end
        btns(0, 0, 0, 0);

        // Down to 449, then down+left: y clamps at 450, x walks left.
        do_reset();
        btns(0, 1, 0, 0);
        for (int k = 1; k <= 126; k++) begin
            tick();
            e = (k <= 15) ? 227 : 227 + 2 * (k - 15);
            if (k == 1 || k == 15 || k == 16 || k == 126)
                chk("down_y", 32'(arrow_y), 32'(e));
        end
        btns(0, 1, 1, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = (k <= 15) ? 303 : 303 - 2 * (k - 15);
            if (k == 1 || k == 15 || k == 16 || k == 17) begin
                chk("diag_x", 32'(arrow_x), 32'(e));
                chk("diag_y", 32'(arrow_y), 32'd450);
            end
        end

        // Up+down together: no vertical motion.
        btns(0, 0, 0, 0);
        tick();
        btns(1, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("updown_y", 32'(arrow_y), 32'd450);
        end
        chk("updown_x", 32'(arrow_x), 32'd299);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
